// File: rtl/paar_seq_engine.sv
// paar_seq_engine: resource-shared evaluator for a PAAR-compressed binarized
// neural network. One adder walks the add/subtract program, one comparator
// thresholds hidden nodes, and one popcount scores classes with a running
// argmax. The features come in through a valid/ready handshake, and the
// prediction goes out through another.
`timescale 1ns/1ps
module paar_seq_engine #(
    parameter int FEAT_CNT   = 12,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int ADDCNT     = 113,
    parameter logic [((ADDCNT > 0) ? ADDCNT : 1)*48-1:0] PAAR0   = '0,
    parameter logic [HIDDEN_CNT*32-1:0]                   YMAP    = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0]            WEIGHTS = '0,
    localparam int PRED_W = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0] features,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PRED_W-1:0]             prediction,
    output logic                          busy
);

    localparam int FULLCNT  = FEAT_CNT + ADDCNT;
    localparam int NODE_W   = $clog2(FEAT_CNT + 1) + FEAT_BITS + 1;
    localparam int SUM_BITS = $clog2(HIDDEN_CNT + 1);
    localparam int IDX_W    = (FULLCNT > 1) ? $clog2(FULLCNT) : 1;
    localparam int OP_W     = (ADDCNT > 1) ? $clog2(ADDCNT) : 1;
    localparam int HID_W    = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADD    = 3'd1,
        ST_THRESH = 3'd2,
        ST_SCORE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // XNOR agreement count between the hidden vector and one weight row
    function automatic logic [SUM_BITS-1:0] popcount(input logic [HIDDEN_CNT-1:0] v);
        logic [SUM_BITS-1:0] acc;
        acc = '0;
        for (int i = 0; i < HIDDEN_CNT; i++) begin
            acc = acc + SUM_BITS'(v[i]);
        end
        return acc;
    endfunction

    state_t                    state_q, state_d;
    logic [OP_W-1:0]           op_cnt_q, op_cnt_d;
    logic [HID_W-1:0]          hid_cnt_q, hid_cnt_d;
    logic [PRED_W-1:0]         cls_cnt_q, cls_cnt_d;
    logic [HIDDEN_CNT-1:0]     hidden_q, hidden_d;
    logic [SUM_BITS-1:0]       best_q, best_d;
    logic [PRED_W-1:0]         best_idx_q, best_idx_d;
    logic                      out_valid_q, out_valid_d;
    logic [PRED_W-1:0]         prediction_q, prediction_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;

    logic signed [NODE_W-1:0]  node_q [0:FULLCNT-1];

    logic                      feat_load_s;
    logic                      node_we_s;
    logic [IDX_W-1:0]          node_waddr_s;
    logic [IDX_W-1:0]          op1_idx_s, op2_idx_s, th_idx_s;
    logic signed [NODE_W-1:0]  rd_a_s, rd_b_s, th_node_s, sum_s;
    logic                      op_add_s, th_pol_s, th_bit_s;
    logic [HIDDEN_CNT-1:0]     w_row_s;
    logic [SUM_BITS-1:0]       score_s;

    // Decode the current program op, threshold entry and weight row
    assign op_add_s     = PAAR0[int'(op_cnt_q)*48];
    assign op1_idx_s    = PAAR0[int'(op_cnt_q)*48 + 16 +: IDX_W];
    assign op2_idx_s    = PAAR0[int'(op_cnt_q)*48 + 32 +: IDX_W];
    assign th_idx_s     = YMAP[int'(hid_cnt_q)*32 +: IDX_W];
    assign th_pol_s     = YMAP[int'(hid_cnt_q)*32 + 16];
    assign w_row_s      = WEIGHTS[int'(cls_cnt_q)*HIDDEN_CNT +: HIDDEN_CNT];

    assign rd_a_s       = node_q[op1_idx_s];
    assign rd_b_s       = node_q[op2_idx_s];
    assign th_node_s    = node_q[th_idx_s];
    assign sum_s        = op_add_s ? (rd_a_s + rd_b_s) : (rd_a_s - rd_b_s);
    assign th_bit_s     = th_pol_s ? ~th_node_s[NODE_W-1] : th_node_s[NODE_W-1];
    assign score_s      = popcount(~(hidden_q ^ w_row_s));
    assign node_waddr_s = IDX_W'(FEAT_CNT) + IDX_W'(op_cnt_q);

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign prediction = prediction_q;
    assign busy       = busy_q;

    // Next-state, counter, hidden/argmax and output computation
    always_comb begin
        state_d      = state_q;
        op_cnt_d     = op_cnt_q;
        hid_cnt_d    = hid_cnt_q;
        cls_cnt_d    = cls_cnt_q;
        hidden_d     = hidden_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        out_valid_d  = out_valid_q;
        prediction_d = prediction_q;
        feat_load_s  = 1'b0;
        node_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    feat_load_s = 1'b1;
                    op_cnt_d    = '0;
                    hid_cnt_d   = '0;
                    cls_cnt_d   = '0;
                    best_d      = '0;
                    best_idx_d  = '0;
                    state_d     = (ADDCNT == 0) ? ST_THRESH : ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                node_we_s = 1'b1;
                if (op_cnt_q == OP_W'(ADDCNT - 1)) begin
                    op_cnt_d = '0;
                    state_d  = ST_THRESH;
                end else begin
                    op_cnt_d = op_cnt_q + OP_W'(1);
                end
            end
            ST_THRESH: begin
                hidden_d[hid_cnt_q] = th_bit_s;
                if (hid_cnt_q == HID_W'(HIDDEN_CNT - 1)) begin
                    hid_cnt_d = '0;
                    state_d   = ST_SCORE;
                end else begin
                    hid_cnt_d = hid_cnt_q + HID_W'(1);
                end
            end
            ST_SCORE: begin
                // Strictly-greater replacement keeps the lowest index on ties
                if ((cls_cnt_q == '0) || (score_s > best_q)) begin
                    best_d     = score_s;
                    best_idx_d = cls_cnt_q;
                end else begin
                    best_d     = best_q;
                    best_idx_d = best_idx_q;
                end
                if (cls_cnt_q == PRED_W'(CLASS_CNT - 1)) begin
                    cls_cnt_d    = '0;
                    out_valid_d  = 1'b1;
                    prediction_d = best_idx_d;
                    state_d      = ST_DONE;
                end else begin
                    cls_cnt_d = cls_cnt_q + PRED_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // Control and output registers with asynchronous abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_cnt_q     <= '0;
            hid_cnt_q    <= '0;
            cls_cnt_q    <= '0;
            hidden_q     <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            out_valid_q  <= 1'b0;
            prediction_q <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_cnt_q     <= op_cnt_d;
            hid_cnt_q    <= hid_cnt_d;
            cls_cnt_q    <= cls_cnt_d;
            hidden_q     <= hidden_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            out_valid_q  <= out_valid_d;
            prediction_q <= prediction_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Node file: parallel feature load on accept, one program result per ADD cycle
    always_ff @(posedge clk) begin
        if (feat_load_s) begin
            for (int i = 0; i < FEAT_CNT; i++) begin
                node_q[i] <= {{(NODE_W-FEAT_BITS){1'b0}}, features[i*FEAT_BITS +: FEAT_BITS]};
            end
        end else if (node_we_s) begin
            node_q[node_waddr_s] <= sum_s;
        end
    end

endmodule
